digit_encoder: RTL and testbench
================================

DIGIT_ENCODER -- requirements
Module: digit_encoder

Interface
REQ-001 Parameter TIMEOUT, default 1023: the maximum number of cycles to wait for Tx_BUSY to rise after a Tx_WR pulse; legal range 1 to 65535.
REQ-002 clk  input  1  the single clock; all logic is rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 digit0..digit3  input  4 each  display digits; digit0 is least significant; 4'b1011 means blank.
REQ-005 send  input  1  request to transmit the current digits as one frame; sampled each cycle.
REQ-006 Tx_BUSY  input  1  busy flag from the UART transmitter; high while a byte is in flight.
REQ-007 Tx_DATA  output  8  the byte presented to the UART transmitter.
REQ-008 Tx_WR  output  1  single-cycle write strobe; Tx_DATA is valid in the same cycle.
REQ-009 busy  output  1  high from frame acceptance until return to IDLE.
REQ-010 done  output  1  single-cycle pulse on successful completion of a frame.
REQ-011 error  output  1  sticky timeout flag; cleared by reset or by the next accepted send.

Function
REQ-012 Frame word W = {digit3, digit2, digit1, digit0}; the SHALL-transmitted word is R, where R[i] = W[15-i] for i = 0..15.
REQ-013 Byte order: the first byte is R[15:8] and the second byte is R[7:0], so the receiving decoder rebuilds the original digits.
REQ-014 The FSM states are IDLE, WR_HI, WAIT_HI_UP, WAIT_HI_DN, WR_LO, WAIT_LO_UP, WAIT_LO_DN, and FIN.
REQ-015 IDLE: when send=1, the block latches digit0..3 into an internal register, clears error, sets busy, and moves to WR_HI on the next cycle.
REQ-016 Digit inputs are ignored after latching; a change mid-frame does not alter the bytes sent.
REQ-017 WR_HI: if Tx_BUSY=0, assert Tx_WR for exactly 1 cycle with Tx_DATA=R[15:8] and move to WAIT_HI_UP; if Tx_BUSY=1, hold in WR_HI with no strobe.
REQ-018 WAIT_HI_UP: on Tx_BUSY=1, move to WAIT_HI_DN; otherwise increment the timeout counter, and when it reaches TIMEOUT, set error, clear busy, and return to IDLE without sending the second byte.
REQ-019 WAIT_HI_DN: on Tx_BUSY=0, move to WR_LO; there is no timeout in this state.
REQ-020 WR_LO, WAIT_LO_UP and WAIT_LO_DN mirror REQ-017 to REQ-019 using R[7:0].
REQ-021 WAIT_LO_DN moves to FIN on Tx_BUSY=0.
REQ-022 FIN: pulse done for 1 cycle, clear busy, and go to IDLE.
REQ-023 send is ignored in every state except IDLE; there is no queuing.
REQ-024 A send present in the same cycle that FIN moves to IDLE is ignored; send is accepted from IDLE only.
REQ-025 The timeout counter is 16 bits, clears on every Tx_WR, and saturates without wrapping.
REQ-026 Tx_DATA holds its last driven byte when Tx_WR=0.
REQ-027 Minimum latency from send to the first Tx_WR is 2 cycles (send sampled in IDLE, then the strobe in WR_HI).
REQ-028 At most one Tx_WR is outstanding at any time; no Tx_WR is issued while Tx_BUSY=1.

Reset
REQ-029 Reset, synchronous and active-high, forces: state=IDLE, Tx_DATA=8'h00, Tx_WR=0, busy=0, done=0, error=0, digit latch=16'hBBBB, timeout counter=0.
REQ-030 Reset asserted mid-frame aborts the frame immediately with no further Tx_WR; Tx_WR is 0 from the first clock edge where reset=1.
REQ-031 Reset has priority over send and over all Tx_BUSY activity.

Verification
REQ-032 Scenario: digits 3,2,1,0 = 1,2,3,4 (W=16'h1234), send pulse, transmitter model gives busy for 10 cycles per byte -> Tx_WR bytes are 8'h2C then 8'h48, done pulses once, busy falls in the same cycle as done.
REQ-033 Scenario: Tx_BUSY held at 1 at the time of send -> no Tx_WR until Tx_BUSY falls, then the first byte is issued 1 cycle later.
REQ-034 Scenario: with TIMEOUT=8, Tx_BUSY never rises after the first strobe -> error=1 after 8 cycles, busy=0, exactly one Tx_WR seen, done never pulses.
REQ-035 Scenario: a second send and changed digits during a frame -> the frame bytes are unchanged and only one frame is sent; a send after done starts a new frame with the new digits.
REQ-036 Scenario: reset asserted in WAIT_LO_DN -> all outputs take their REQ-029 values on the next edge, with no second-byte completion and no done pulse.
REQ-037 Scenario: all digits blank (W=16'hBBBB) -> bytes are 8'hDD, 8'hDD.

Source files
------------

// File: rtl/digit_encoder.sv
// Digit-to-UART frame encoder.
// Latches four BCD-style digits on a send request, bit-reverses the 16-bit
// word and hands it to a byte-wide UART transmitter as two bytes, high first.
// Each byte waits for the transmitter's busy flag to rise and then fall.
// A transmitter that never acknowledges a byte aborts the frame and raises a
// sticky error.

module digit_encoder #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic       send,
  input  logic       Tx_BUSY,
  output logic [7:0] Tx_DATA,
  output logic       Tx_WR,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    StIdle,
    StWrHi,
    StWaitHiUp,
    StWaitHiDn,
    StWrLo,
    StWaitLoUp,
    StWaitLoDn,
    StFin
  } state_e;

  // Reset value of the digit latch: four blank digits.
  localparam logic [15:0] BlankWord  = 16'hBBBB;
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [15:0] word_rev;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic        timeout_hit;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_wr_q, tx_wr_d;
  logic        error_q, error_d;

  // Bit-reverse the latched word so the receiver rebuilds the digits.
  always_comb begin
    word_rev = '0;
    for (int i = 0; i < 16; i++) begin
      word_rev[i] = word_q[15-i];
    end
  end

  // Saturating increment of the acknowledge-wait counter.
  always_comb begin
    cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    timeout_hit = (cnt_inc >= TimeoutVal);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (send) state_d = StWrHi;
      end
      StWrHi: begin
        if (!Tx_BUSY) state_d = StWaitHiUp;
      end
      StWaitHiUp: begin
        if (Tx_BUSY)          state_d = StWaitHiDn;
        else if (timeout_hit) state_d = StIdle;
      end
      StWaitHiDn: begin
        if (!Tx_BUSY) state_d = StWrLo;
      end
      StWrLo: begin
        if (!Tx_BUSY) state_d = StWaitLoUp;
      end
      StWaitLoUp: begin
        if (Tx_BUSY)          state_d = StWaitLoDn;
        else if (timeout_hit) state_d = StIdle;
      end
      StWaitLoDn: begin
        if (!Tx_BUSY) state_d = StFin;
      end
      StFin: begin
        // A send seen here is deliberately dropped; only IDLE accepts.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: digit latch, strobe/byte, counter, sticky error.
  always_comb begin
    word_d    = word_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    cnt_d     = cnt_q;
    error_d   = error_q;
    unique case (state_q)
      StIdle: begin
        if (send) begin
          word_d  = {digit3, digit2, digit1, digit0};
          error_d = 1'b0;
          cnt_d   = '0;
        end
      end
      StWrHi: begin
        if (!Tx_BUSY) begin
          tx_wr_d   = 1'b1;
          tx_data_d = word_rev[15:8];
          cnt_d     = '0;
        end
      end
      StWrLo: begin
        if (!Tx_BUSY) begin
          tx_wr_d   = 1'b1;
          tx_data_d = word_rev[7:0];
          cnt_d     = '0;
        end
      end
      StWaitHiUp, StWaitLoUp: begin
        if (!Tx_BUSY) begin
          cnt_d = cnt_inc;
          if (timeout_hit) error_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; strobe and byte are registered so they leave together.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q    <= BlankWord;
      tx_data_q <= 8'h00;
      tx_wr_q   <= 1'b0;
      cnt_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      word_q    <= word_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      cnt_q     <= cnt_d;
      error_q   <= error_d;
    end
  end

  // Outputs: busy/done decode directly from state so they switch together.
  always_comb begin
    Tx_DATA = tx_data_q;
    Tx_WR   = tx_wr_q;
    error   = error_q;
    done    = (state_q == StFin);
    busy    = (state_q != StIdle) && (state_q != StFin);
  end

  // A strobe is always followed by a wait state, never by another strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(tx_wr_q && tx_wr_d));
    end
  end

endmodule

// File: tb/tb_digit_encoder.sv
// Randomized bench for digit_encoder with a reactive UART transmitter model.
// Expected bytes come from bit-reversing the digit word in the bench.

module tb_digit_encoder;

  localparam int unsigned Tmo = 8;

  logic       clk;
  logic       reset;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       send;
  logic       Tx_BUSY;
  logic [7:0] Tx_DATA;
  logic       Tx_WR;
  logic       busy, done, error;

  int n_checks;
  int n_errors;
  int cyc;
  logic [7:0] exp_q[$];

  digit_encoder #(.TIMEOUT(Tmo)) dut (
    .clk     (clk),
    .reset   (reset),
    .digit0  (digit0),
    .digit1  (digit1),
    .digit2  (digit2),
    .digit3  (digit3),
    .send    (send),
    .Tx_BUSY (Tx_BUSY),
    .Tx_DATA (Tx_DATA),
    .Tx_WR   (Tx_WR),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Transmitted word: bit i of the result is bit 15-i of the digit word.
  function automatic logic [15:0] ref_frame(input logic [15:0] w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r = (r << 1) | ((w >> i) & 16'd1);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_digits(input logic [15:0] w);
    {digit3, digit2, digit1, digit0} = w;
  endtask

  // mode 0: normal, 1: transmitter never acknowledges, 2: Tx_BUSY high at send,
  // 3: reset while the second byte is in flight. len 0 picks a random busy time.
  task automatic run_frame(input logic [15:0] w, input int mode, input bit disturb,
                           input int len);
    logic [15:0] r;
    int  wr_seen, done_seen, wr_cyc, rel, tx_left, tx_delay, blen, bad;
    bit  prev_busy, ended, err_seen;
    r = ref_frame(w);
    exp_q.delete();
    exp_q.push_back(r[15:8]);
    if (mode != 1) exp_q.push_back(r[7:0]);
    set_digits(w);
    rel       = int'($urandom_range(3, 6));
    Tx_BUSY   = (mode == 2);
    tx_left   = 0;
    tx_delay  = -1;
    wr_seen   = 0;
    done_seen = 0;
    wr_cyc    = 0;
    ended     = 1'b0;
    err_seen  = 1'b0;
    send      = 1'b1;
    cyc       = 0;
    step();
    send = 1'b0;
    check_eq("accept_busy", busy, 1);
    check_eq("accept_err_clr", error, 0);
    for (int k = 0; k < 300 && !ended; k++) begin
      prev_busy = Tx_BUSY;
      step();
      send = 1'b0;
      if (Tx_WR) begin
        wr_seen++;
        wr_cyc = cyc;
        check_eq("wr_while_busy", prev_busy, 0);
        if (exp_q.size() == 0) check_eq("extra_wr", 1, 0);
        else check_eq("byte", Tx_DATA, exp_q.pop_front());
        if (wr_seen == 1) check_eq("first_latency", cyc, (mode == 2) ? rel + 1 : 2);
        if (mode != 1) tx_delay = int'($urandom_range(0, 3));
      end
      // Transmitter model.
      if (mode == 2 && wr_seen == 0 && cyc == rel) begin
        Tx_BUSY = 1'b0;
      end else if (tx_delay > 0) begin
        tx_delay--;
      end else if (tx_delay == 0) begin
        blen     = (len > 0) ? len : int'($urandom_range(1, 10));
        Tx_BUSY  = 1'b1;
        tx_left  = blen;
        tx_delay = -1;
      end else if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) Tx_BUSY = 1'b0;
      end
      if (mode == 1 && error && !err_seen) begin
        err_seen = 1'b1;
        check_eq("timeout_cycles", cyc - wr_cyc, Tmo);
        check_eq("timeout_busy", busy, 0);
      end
      if (mode == 3 && wr_seen == 2 && prev_busy) begin
        // Edge just sampled Tx_BUSY=1 after the second strobe: in WAIT_LO_DN.
        reset = 1'b1;
        step();
        check_eq("rst_wr", Tx_WR, 0);
        check_eq("rst_data", Tx_DATA, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        Tx_BUSY = 1'b0;
        step();
        reset = 1'b0;
        ended = 1'b1;
      end else if (done) begin
        done_seen++;
        check_eq("done_busy_low", busy, 0);
        check_eq("done_all_bytes", exp_q.size(), 0);
        check_eq("data_hold", Tx_DATA, r[7:0]);
        send = 1'b1;  // must be ignored in FIN
      end else if (!busy) begin
        ended = 1'b1;
      end else if (disturb && $urandom_range(0, 3) == 0) begin
        send = 1'b1;
        set_digits(16'($urandom()));
      end
    end
    send    = 1'b0;
    Tx_BUSY = 1'b0;
    if (!ended) check_eq("frame_bound", 0, 1);
    check_eq("wr_count", wr_seen, (mode == 1) ? 1 : 2);
    check_eq("done_count", done_seen, (mode == 0 || mode == 2) ? 1 : 0);
    if (mode == 1) check_eq("error_set", error, 1);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (Tx_WR || busy || done) bad++;
    end
    check_eq("idle_quiet", bad, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    reset    = 1'b1;
    send     = 1'b0;
    Tx_BUSY  = 1'b0;
    set_digits(16'h0000);
    repeat (3) step();
    reset = 1'b0;
    check_eq("reset_wr", Tx_WR, 0);
    check_eq("reset_data", Tx_DATA, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_error", error, 0);

    run_frame(16'h1234, 0, 1'b0, 10);
    run_frame(16'hBBBB, 0, 1'b0, 0);
    run_frame(16'($urandom()), 2, 1'b0, 0);
    run_frame(16'($urandom()), 1, 1'b0, 0);
    check_eq("error_sticky", error, 1);
    run_frame(16'($urandom()), 0, 1'b1, 0);
    run_frame(16'hA5C3, 3, 1'b0, 6);
    for (int n = 0; n < 20; n++) begin
      run_frame(16'($urandom()), ($urandom_range(0, 1) == 0) ? 0 : 2,
                1'($urandom_range(0, 1)), 0);
    end
    run_frame(16'($urandom()), 1, 1'b1, 0);
    run_frame(16'($urandom()), 0, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
